// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - operation encoding and bitwise helper for gate_array_unit
package gate_pkg;

    localparam int GATE_OP_W  = 3;
    localparam int GATE_MAX_W = 64;

    typedef enum logic [GATE_OP_W-1:0] {
        G_AND  = 3'd0,
        G_OR   = 3'd1,
        G_XOR  = 3'd2,
        G_NAND = 3'd3,
        G_NOR  = 3'd4,
        G_XNOR = 3'd5,
        G_NOT  = 3'd6,
        G_PASS = 3'd7
    } gate_op_e;

    // Computed at the widest supported width; callers truncate to their own width.
    function automatic logic [GATE_MAX_W-1:0] apply_op(
        input gate_op_e              op,
        input logic [GATE_MAX_W-1:0] a,
        input logic [GATE_MAX_W-1:0] b
    );
        logic [GATE_MAX_W-1:0] r;
        case (op)
            G_AND:   r = a & b;
            G_OR:    r = a | b;
            G_XOR:   r = a ^ b;
            G_NAND:  r = ~(a & b);
            G_NOR:   r = ~(a | b);
            G_XNOR:  r = ~(a ^ b);
            G_NOT:   r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_op.sv
// rtl/bitwise_op.sv - combinational WIDTH-bit eight-operation logic stage
module bitwise_op
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  gate_op_e         op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Pure bitwise evaluation; no carries between bit positions.
    always_comb begin
        y = WIDTH'(apply_op(op, GATE_MAX_W'(a), GATE_MAX_W'(b)));
    end

endmodule

// File: rtl/gate_array_unit.sv
// rtl/gate_array_unit.sv - registered bitwise logic unit, optional GATE_ACCUM_EN reduction mode
module gate_array_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [GATE_OP_W-1:0] op,
    input  logic [WIDTH-1:0]     p,
    input  logic [WIDTH-1:0]     q,
    input  logic                 acc,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic [WIDTH-1:0]     s,
    output logic                 s_zero,
    output logic [CNTW-1:0]      s_count,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_y;
    logic             res_load;
    logic [WIDTH-1:0] res_s;
    logic [CNTW-1:0]  res_cnt;

    // A stalled result blocks new beats in the same cycle; a consumed one frees the slot with no bubble.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    bitwise_op #(.WIDTH(WIDTH)) u_bitwise_op (
        .op (gate_op_e'(op)),
        .a  (op_a),
        .b  (op_b),
        .y  (op_y)
    );

`ifdef GATE_ACCUM_EN
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next;
    logic [CNTW-1:0]  cnt_r;
    logic [CNTW-1:0]  cnt_next;
    logic             start;
    logic             fold;

    // A stream opens on in_first or whenever no stream is open (cnt_r == 0).
    assign start = in_first || (cnt_r == '0);
    assign fold  = acc && !start;
    assign op_a  = fold ? acc_r : p;
    assign op_b  = fold ? p : q;

    // Next accumulator value and saturating beat count for an accumulate beat.
    always_comb begin
        acc_next = op_y;
        cnt_next = cnt_r;
        if (start) begin
            acc_next = p;
            cnt_next = CNTW'(1);
        end else if (cnt_r != {CNTW{1'b1}}) begin
            cnt_next = cnt_r + 1'b1;
        end
    end

    // Stream state; plain beats leave it untouched, a last beat closes the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (accept && acc) begin
            if (in_last) begin
                acc_r <= '0;
                cnt_r <= '0;
            end else begin
                acc_r <= acc_next;
                cnt_r <= cnt_next;
            end
        end
    end

    assign res_load = accept && (!acc || in_last);
    assign res_s    = acc ? acc_next : op_y;
    assign res_cnt  = acc ? cnt_next : CNTW'(1);
`else
    logic unused_accum_ports;

    assign unused_accum_ports = &{1'b0, acc, in_first, in_last};
    assign op_a     = p;
    assign op_b     = q;
    assign res_load = accept;
    assign res_s    = op_y;
    assign res_cnt  = CNTW'(1);
`endif

    // Result register: load on a producing beat, drop valid once consumed, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            s_zero    <= 1'b1;
            s_count   <= '0;
            out_valid <= 1'b0;
        end else if (res_load) begin
            s         <= res_s;
            s_zero    <= (res_s == '0);
            s_count   <= res_cnt;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_array_unit.sv
// tb/tb_gate_array_unit.sv - scoreboard testbench for gate_array_unit
module tb_gate_array_unit;

    localparam int WIDTH = 8;
    localparam int CNTW  = 8;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [CNTW-1:0]  cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic             acc;
    logic             in_first;
    logic             in_last;
    logic [WIDTH-1:0] s;
    logic             s_zero;
    logic [CNTW-1:0]  s_count;
    logic             out_valid;
    logic             out_ready;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    gate_array_unit #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .p         (p),
        .q         (q),
        .acc       (acc),
        .in_first  (in_first),
        .in_last   (in_last),
        .s         (s),
        .s_zero    (s_zero),
        .s_count   (s_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic logic [WIDTH-1:0] model_op(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Monitor: every output transfer is compared against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("s", s, e.s);
                check_eq("s_zero", s_zero, e.s == '0);
                check_eq("s_count", s_count, e.cnt);
            end
        end
    end

    // Drive one beat from posedge+1, wait (bounded) for acceptance, return at posedge+1.
    task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ac, input logic f, input logic l,
                        input logic has_exp, input logic [WIDTH-1:0] es, input logic [CNTW-1:0] ec);
        int n;
        in_valid = 1'b1; op = o; p = a; q = b; acc = ac; in_first = f; in_last = l;
        if (has_exp) exp_q.push_back('{s: es, cnt: ec});
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; acc = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    // Accumulate beat; without the feature every beat is plain against q = 0.
    task automatic send_acc(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic f, input logic l,
                            input logic has_exp, input logic [WIDTH-1:0] es, input logic [CNTW-1:0] ec);
`ifdef GATE_ACCUM_EN
        send(o, a, '0, 1'b1, f, l, has_exp, es, ec);
`else
        send(o, a, '0, 1'b1, f, l, 1'b1, model_op(o, a, '0), CNTW'(1));
`endif
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] tbl [8];
        tbl = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
        rst_n = 1'b0; in_valid = 1'b0; op = '0; p = '0; q = '0;
        acc = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_s", s, 0);
        check_eq("rst_s_zero", s_zero, 1);
        check_eq("rst_s_count", s_count, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All eight operations back to back.
        for (int i = 0; i < 8; i++) send(3'(i), 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, tbl[i], CNTW'(1));
        drain();

        // Single-bit AND truth table on bit 0.
        for (int i = 0; i < 4; i++)
            send(3'd0, WIDTH'(i >> 1), WIDTH'(i & 1), 1'b0, 1'b0, 1'b0, 1'b1, WIDTH'(i == 3), CNTW'(1));
        drain();

        // Randomised plain beats against the model.
        for (int i = 0; i < 12; i++) begin
            logic [2:0]       ro;
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ro = 3'($urandom_range(0, 7)); ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            send(ro, ra, rb, 1'b0, 1'b0, 1'b0, 1'b1, model_op(ro, ra, rb), CNTW'(1));
        end
        drain();

        // Backpressure: result held 3 cycles, in_ready low, then next result one cycle after acceptance.
        out_ready = 1'b0;
        send(3'd2, 8'h5A, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, CNTW'(1));
        in_valid = 1'b1; op = 3'd1; p = 8'h81; q = 8'h18;
        exp_q.push_back('{s: 8'h99, cnt: CNTW'(1)});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_s_hold", s, 8'h55);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("release_out_valid", out_valid, 1);
        check_eq("release_s", s, 8'h99);
        drain();

        // Accumulate stream and single-beat stream.
        send_acc(3'd2, 8'h01, 1'b1, 1'b0, 1'b0, '0, '0);
        send_acc(3'd2, 8'h02, 1'b0, 1'b0, 1'b0, '0, '0);
        send_acc(3'd2, 8'h04, 1'b0, 1'b0, 1'b0, '0, '0);
        send_acc(3'd2, 8'h08, 1'b0, 1'b1, 1'b1, 8'h0F, CNTW'(4));
        send_acc(3'd2, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, CNTW'(1));
        drain();

        // Stream restart discards the partial stream.
        send_acc(3'd0, 8'hFF, 1'b1, 1'b0, 1'b0, '0, '0);
        send_acc(3'd0, 8'h0F, 1'b0, 1'b0, 1'b0, '0, '0);
        send_acc(3'd1, 8'h11, 1'b1, 1'b0, 1'b0, '0, '0);
        send_acc(3'd1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, CNTW'(2));
        drain();

        // Reset mid-stream; outputs return to reset values without waiting for a clock edge.
        send_acc(3'd2, 8'h33, 1'b1, 1'b0, 1'b0, '0, '0);
        send_acc(3'd2, 8'h44, 1'b0, 1'b0, 1'b0, '0, '0);
        drain();
        send(3'd7, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, CNTW'(1));
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("midrst_s", s, 0);
        check_eq("midrst_s_zero", s_zero, 1);
        check_eq("midrst_s_count", s_count, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_acc(3'd2, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, CNTW'(1));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
